// File: rtl/write_back_cache.sv
// Set-associative write-back cache with a single-port-per-way line store and a
// word-serial WB/REFILL engine toward external memory.

module wbc_way #(
  parameter int INDEX_BITS = 5,
  parameter int WORD_BITS  = 4,
  parameter int TAG_BITS   = 21,
  parameter int WORD_SIZE  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] index,
  input  logic [WORD_BITS-1:0]  word,
  input  logic [TAG_BITS-1:0]   tag,
  input  logic                  wr_en,
  input  logic [WORD_SIZE-1:0]  wr_data,
  input  logic                  set_dirty,
  input  logic                  fill,
  output logic                  hit,
  output logic                  valid,
  output logic                  dirty,
  output logic [TAG_BITS-1:0]   tag_out,
  output logic [WORD_SIZE-1:0]  rd_data
);
  localparam int SETS  = 2**INDEX_BITS;
  localparam int WORDS = 2**WORD_BITS;

  logic [SETS-1:0]      valid_q, dirty_q;
  logic [TAG_BITS-1:0]  tag_q  [SETS];
  logic [WORD_SIZE-1:0] data_q [SETS*WORDS];

  assign valid   = valid_q[index];
  assign dirty   = dirty_q[index];
  assign tag_out = tag_q[index];
  assign hit     = valid & (tag_out == tag);
  assign rd_data = data_q[{index, word}];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (set_dirty) begin
      dirty_q[index] <= 1'b1;
    end
  end

  // Tags and data carry no reset; valid gates every use of them.
  always_ff @(posedge clk) begin
    if (fill) tag_q[index] <= tag;
  end

  always_ff @(posedge clk) begin
    if (wr_en) data_q[{index, word}] <= wr_data;
  end
endmodule

module write_back_cache #(
  parameter int INDEX_BITS   = 5,
  parameter int BLOCK_OFFSET = 6,
  parameter int WAYS         = 2,
  parameter int WORD_SIZE    = 32,
  parameter int TAG_BITS     = 32 - INDEX_BITS - BLOCK_OFFSET
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [31:0]          addr,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic                 wr,
  input  logic                 re,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 stall,
  output logic [31:0]          ext_addr,
  output logic [WORD_SIZE-1:0] ext_data_out,
  input  logic [WORD_SIZE-1:0] ext_data_in,
  output logic                 ext_wr,
  output logic                 ext_re,
  input  logic                 ext_ack
);
  localparam int SETS      = 2**INDEX_BITS;
  localparam int WORD_BITS = BLOCK_OFFSET - 2;
  localparam int WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, WB, REFILL, DONE} state_t;

  state_t                          state, state_n;
  logic [WORD_BITS-1:0]            cnt;
  logic [SETS-1:0][WAY_BITS-1:0]   victim_ptr;
  logic [WAY_BITS-1:0]             victim_way, victim_sel;
  logic [TAG_BITS-1:0]             req_tag;
  logic [INDEX_BITS-1:0]           req_index;

  logic [TAG_BITS-1:0]             addr_tag, acc_tag;
  logic [INDEX_BITS-1:0]           addr_index, acc_index;
  logic [WORD_BITS-1:0]            addr_word, acc_word;

  logic [WAYS-1:0]                 way_hit, way_valid, way_dirty;
  logic [WAYS-1:0]                 way_wr_en, way_set_dirty, way_fill;
  logic [WAYS-1:0][TAG_BITS-1:0]   way_tag;
  logic [WAYS-1:0][WORD_SIZE-1:0]  way_word;
  logic [WORD_SIZE-1:0]            way_wr_data, hit_word;

  logic req, hit_any, wr_hit, refill_we, fill, found;
  logic unused_addr_lsb;

  assign addr_tag   = addr[31 -: TAG_BITS];
  assign addr_index = addr[BLOCK_OFFSET +: INDEX_BITS];
  assign addr_word  = addr[BLOCK_OFFSET-1:2];
  assign unused_addr_lsb = ^addr[1:0];

  // IDLE looks up the live request; the miss engine walks the latched line.
  assign acc_tag   = (state == IDLE) ? addr_tag   : req_tag;
  assign acc_index = (state == IDLE) ? addr_index : req_index;
  assign acc_word  = (state == IDLE) ? addr_word  : cnt;

  assign req         = enable & (re | wr);
  assign hit_any     = |way_hit;
  assign way_wr_data = (state == IDLE) ? data_in : ext_data_in;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    wbc_way #(
      .INDEX_BITS(INDEX_BITS), .WORD_BITS(WORD_BITS),
      .TAG_BITS(TAG_BITS),     .WORD_SIZE(WORD_SIZE)
    ) u_way (
      .clk      (clk),
      .rst      (rst),
      .index    (acc_index),
      .word     (acc_word),
      .tag      (acc_tag),
      .wr_en    (way_wr_en[g]),
      .wr_data  (way_wr_data),
      .set_dirty(way_set_dirty[g]),
      .fill     (way_fill[g]),
      .hit      (way_hit[g]),
      .valid    (way_valid[g]),
      .dirty    (way_dirty[g]),
      .tag_out  (way_tag[g]),
      .rd_data  (way_word[g])
    );
  end

  // Lowest invalid way wins; otherwise round-robin pointer of the set.
  always_comb begin
    hit_word   = '0;
    victim_sel = victim_ptr[addr_index];
    found      = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) hit_word = hit_word | way_word[w];
      if (!found && !way_valid[w]) begin
        victim_sel = WAY_BITS'(w);
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    state_n      = state;
    stall        = 1'b0;
    ext_wr       = 1'b0;
    ext_re       = 1'b0;
    ext_addr     = '0;
    ext_data_out = '0;
    data_out     = '0;
    wr_hit       = 1'b0;
    refill_we    = 1'b0;
    fill         = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (req) begin
            if (hit_any) begin
              data_out = hit_word;
              wr_hit   = wr & ~re;
            end else begin
              stall   = 1'b1;
              state_n = (way_valid[victim_sel] & way_dirty[victim_sel]) ? WB : REFILL;
            end
          end
        end
        WB: begin
          stall        = 1'b1;
          ext_wr       = 1'b1;
          ext_addr     = {way_tag[victim_way], req_index, cnt, 2'b00};
          ext_data_out = way_word[victim_way];
          if (ext_ack && (&cnt)) state_n = REFILL;
        end
        REFILL: begin
          stall     = 1'b1;
          ext_re    = 1'b1;
          ext_addr  = {req_tag, req_index, cnt, 2'b00};
          refill_we = ext_ack;
          if (ext_ack && (&cnt)) state_n = DONE;
        end
        DONE: begin
          stall   = 1'b1;
          fill    = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      way_set_dirty[w] = wr_hit & way_hit[w];
      way_wr_en[w]     = (wr_hit & way_hit[w]) |
                         (refill_we & (victim_way == WAY_BITS'(w)));
      way_fill[w]      = fill & (victim_way == WAY_BITS'(w));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      victim_ptr <= '0;
      victim_way <= '0;
      req_tag    <= '0;
      req_index  <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (state_n != IDLE) begin
            victim_way <= victim_sel;
            req_tag    <= addr_tag;
            req_index  <= addr_index;
            cnt        <= '0;
          end
        end
        WB, REFILL: begin
          // A state change here always follows the last word, so restart at 0.
          if (ext_ack) cnt <= (state_n != state) ? '0 : cnt + WORD_BITS'(1);
        end
        DONE: begin
          victim_ptr[req_index] <= (victim_ptr[req_index] == WAY_BITS'(WAYS - 1)) ?
                                   '0 : victim_ptr[req_index] + WAY_BITS'(1);
        end
        default: ;
      endcase
    end
  end
endmodule
